// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg
// Shared sizing constants and the write-controller state type.
//   DATA_W : register data width
//   ADDR_W : register address width
//   NREG   : number of registers (2**ADDR_W)
//   state_e: CLEAR (re-zeroing the file) / ARB (arbitrating requesters)
package regfile_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_wr_ctrl_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter. When both requesters are valid the
// one selected by the priority pointer wins; a lone valid always wins.
// The pointer moves to the other requester after every grant that is
// actually taken (advance high) and holds otherwise.
//   clk     in   clock
//   rst     in   synchronous active-high reset (pointer -> requester 0)
//   valid   in   [1:0] request valids
//   advance in   grant is consumed this cycle
//   grant   out  [1:0] one-hot (or zero) grant, combinational
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After serving requester i the pointer favours 1-i.
    always_comb begin
        prio_d = prio_q;
        if (advance && grant[0]) begin
            prio_d = 1'b1;
        end else if (advance && grant[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl
// Write-port controller for a small register file. After reset (or on a
// clear request) it zeroes every register in ascending address order,
// then arbitrates two write requesters round-robin. An accepted request
// is presented on the registered write port in the following cycle.
//
// state | meaning
// CLEAR | issuing one zero write per cycle, requesters held off
// ARB   | granting requester writes, watching clear_req
//
//   clk, rst                      clock, synchronous active-high reset
//   clear_req                     re-zero all registers (ignored while clearing)
//   reqN_valid/addr/data/ready    requester N write handshake (N = 0, 1)
//   we, addre_wr, D               registered register-file write port
//   busy                          high while in CLEAR
//   clear_done                    pulse with the final clear write
module regfile_wr_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              we,
    output logic [ADDR_W-1:0] addre_wr,
    output logic [DATA_W-1:0] D,
    output logic              busy,
    output logic              clear_done
);

    import regfile_ctrl_pkg::*;

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] clr_idx_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              clear_done_q;

    logic              arb_open;
    logic [1:0]        grant;

    // A pending clear_req blocks grants in the same cycle so nothing is
    // accepted that the clear would immediately overwrite.
    assign arb_open = (state_q == ARB) && !clear_req;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .advance (arb_open),
        .grant   (grant)
    );

    assign req0_ready = arb_open && grant[0];
    assign req1_ready = arb_open && grant[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            clear_done_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    we_q         <= 1'b1;
                    addr_q       <= clr_idx_q;
                    data_q       <= '0;
                    clear_done_q <= (clr_idx_q == LAST_IDX);
                    clr_idx_q    <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LAST_IDX) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    clear_done_q <= 1'b0;
                    if (clear_req) begin
                        state_q   <= CLEAR;
                        clr_idx_q <= '0;
                        we_q      <= 1'b0;
                    end else begin
                        // addr/data hold when nothing was accepted
                        we_q <= req0_ready || req1_ready;
                        if (req0_ready) begin
                            addr_q <= req0_addr;
                            data_q <= req0_data;
                        end else if (req1_ready) begin
                            addr_q <= req1_addr;
                            data_q <= req1_data;
                        end
                    end
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_idx_q <= '0;
                    we_q      <= 1'b0;
                end
            endcase
        end
    end

    assign we         = we_q;
    assign addre_wr   = addr_q;
    assign D          = data_q;
    assign clear_done = clear_done_q;
    assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Testbench for regfile_wr_ctrl: directed scenarios followed by random
// traffic, all checked against a behavioural model of the controller.
module tb_regfile_wr_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          we;
    logic [AW-1:0] addre_wr;
    logic [DW-1:0] D;
    logic          busy;
    logic          clear_done;

    always #5 clk = ~clk;

    regfile_wr_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .we         (we),
        .addre_wr   (addre_wr),
        .D          (D),
        .busy       (busy),
        .clear_done (clear_done)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: "clearing" with the next address to zero, the
    // round-robin pointer, and the write the port should show this cycle.
    bit            m_clearing;
    int            m_idx;
    bit            m_prio;
    bit            m_we;
    int            m_addr;
    logic [DW-1:0] m_data;
    bit            m_done;

    logic [DW-1:0] rf      [NR];
    logic [DW-1:0] exp_mem [NR];

    bit            got0, got1, saw_done, cur_we;
    int            cur_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clearing = 1'b1;
        m_idx      = 0;
        m_prio     = 1'b0;
        m_we       = 1'b0;
        m_addr     = 0;
        m_data     = '0;
        m_done     = 1'b0;
    endtask

    // One clock: check at the falling edge, advance the model, then return
    // just after the next rising edge so the caller can drive new inputs.
    task automatic cycle();
        bit g0, g1;
        @(negedge clk);
        g0 = !m_clearing && !clear_req && req0_valid && (!req1_valid || !m_prio);
        g1 = !m_clearing && !clear_req && req1_valid && (!req0_valid || m_prio);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("one_ready", req0_ready & req1_ready, 0);
        chk("busy", busy, m_clearing);
        chk("we", we, m_we);
        chk("addre_wr", addre_wr, m_addr);
        chk("D", D, m_data);
        chk("clear_done", clear_done, m_done);
        if (we === 1'b1) rf[addre_wr] = D;
        if (m_we) exp_mem[m_addr] = m_data;
        got0     = req0_ready;
        got1     = req1_ready;
        saw_done = clear_done;
        cur_we   = we;
        cur_addr = int'(addre_wr);

        if (rst) begin
            model_reset();
        end else if (m_clearing) begin
            m_we   = 1'b1;
            m_addr = m_idx;
            m_data = '0;
            m_done = (m_idx == NR - 1);
            if (m_idx == NR - 1) m_clearing = 1'b0;
            m_idx  = (m_idx + 1) % NR;
        end else if (clear_req) begin
            m_clearing = 1'b1;
            m_idx      = 0;
            m_we       = 1'b0;
            m_done     = 1'b0;
        end else begin
            m_done = 1'b0;
            m_we   = g0 || g1;
            if (g0) begin
                m_addr = int'(req0_addr);
                m_data = req0_data;
                m_prio = 1'b1;
            end else if (g1) begin
                m_addr = int'(req1_addr);
                m_data = req1_data;
                m_prio = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Requesters hold a pending request until it is accepted.
    task automatic rand_reqs();
        if (!req0_valid || got0) begin
            req0_valid = 1'($urandom_range(0, 1));
            req0_addr  = AW'($urandom);
            req0_data  = DW'($urandom);
        end
        if (!req1_valid || got1) begin
            req1_valid = 1'($urandom_range(0, 1));
            req1_addr  = AW'($urandom);
            req1_data  = DW'($urandom);
        end
    endtask

    initial begin
        bit found;
        rst        = 1'b1;
        clear_req  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_data  = '0;
        req1_data  = '0;
        for (int i = 0; i < NR; i++) begin
            rf[i]      = 'x;
            exp_mem[i] = 'x;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state, release, then the 8-write clear sequence.
        cycle();
        rst = 1'b0;
        cycle();
        for (int i = 0; i < NR; i++) begin
            cycle();
            chk("clr_we", cur_we, 1);
            chk("clr_addr", cur_addr, i);
            chk("clr_done_pulse", saw_done, (i == NR - 1));
        end
        cycle();

        // Single requesters.
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'd10;
        cycle();
        chk("r31_ready0", got0, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 3'd3; req1_data = 16'd8;
        cycle();
        chk("r31_ready1", got1, 1);
        req1_valid = 1'b0;
        cycle();
        cycle();
        chk("r31_reg3", rf[3], 16'd8);
        chk("r31_reg1", rf[1], 16'd10);

        // Continuous dual requests alternate.
        req0_valid = 1'b1; req0_addr = 3'd7; req0_data = 16'd20;
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 16'd1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("r32_grant0", got0, (k % 2 == 0));
            chk("r32_grant1", got1, (k % 2 == 1));
        end
        req1_valid = 1'b0;
        cycle();
        chk("r32_tail0", got0, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        cycle();
        chk("r32_tail1", got1, 1);

        // Same-address collision, pointer back on requester 0.
        req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 16'hAAAA;
        req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'h5555;
        cycle();
        chk("r33_first", got0, 1);
        req0_valid = 1'b0;
        cycle();
        chk("r33_second", got1, 1);
        chk("r33_reg2_mid", rf[2], 16'hAAAA);
        req1_valid = 1'b0;
        cycle();
        cycle();
        chk("r33_reg2_final", rf[2], 16'h5555);

        // clear_req while requester 0 waits.
        req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 16'h1234;
        clear_req  = 1'b1;
        cycle();
        chk("r34_blocked", got0, 0);
        clear_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            cycle();
            if (saw_done) begin
                found = 1'b1;
                chk("r34_grant_first_arb", got0, 1);
            end
        end
        chk("r34_clear_done_seen", found, 1);
        req0_valid = 1'b0;
        cycle();
        cycle();
        chk("r34_reg6", rf[6], 16'h1234);

        // Reset in the middle of a clear.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h0101;
        req1_valid = 1'b1; req1_addr = 3'd4; req1_data = 16'h0404;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            cycle();
            if (cur_we && cur_addr == 4) found = 1'b1;
        end
        chk("r35_reached_addr4", found, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("r35_idle_after_rst", cur_we, 0);
        for (int i = 0; i < NR; i++) begin
            cycle();
            chk("r35_clr_addr", cur_addr, i);
            if (i < NR - 1) chk("r35_no_ready", got0 | got1, 0);
        end

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            clear_req = ($urandom_range(0, 19) == 0);
            rand_reqs();
            cycle();
        end
        rst        = 1'b0;
        clear_req  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (12) cycle();
        for (int i = 0; i < NR; i++) chk("final_mem", rf[i], exp_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
